matrix_loader: RTL
==================

Name: matrix_loader

Overview:
- Upstream stage of the 3x3 determinant unit.
- Accepts matrix elements one per handshake from the HPS-side element stream and assembles them into the packed 3x3 signed matrix bus the determinant stage consumes.
- Presents the full matrix with a valid/ready handshake.
- Also supports 2x2 matrices, embedded so that the downstream 3x3 determinant equals the 2x2 determinant.

Parameters:
- ELEM_W, 8, width in bits of one signed matrix element; packed matrix width is 9*ELEM_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- clear  input  1  synchronous abort of a partial or held matrix.
- size_sel  input  1  0 = 3x3 (9 elements), 1 = 2x2 (4 elements); sampled with the first element of each matrix.
- in_data  input  ELEM_W  signed element, row-major order.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts an element this cycle.
- out_matrix  output  9*ELEM_W  packed matrix, a11 at [71:64] down to a33 at [7:0] (row-major, MSB first).
- out_valid  output  1  out_matrix is complete and stable.
- out_ready  input  1  downstream consumes the matrix.
- out_size  output  1  size_sel latched for the presented matrix.
- elem_cnt  output  4  number of elements accepted for the current matrix (0..9).

Behaviour:
- Accept: element accepted when in_valid && in_ready on a rising edge.
- Present: matrix transferred when out_valid && out_ready.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Reset (rst=0 at an edge): state=LOAD, elem_cnt=0, out_valid=0, out_size=0, out_matrix=0. in_ready is driven 0 while rst is low.
- Element placement, 3x3: accepted element k (k=elem_cnt, 0..8) written to bits [9*ELEM_W-1-ELEM_W*k -: ELEM_W].
- Element placement, 2x2:
  - k=0→a11, k=1→a12, k=2→a21, k=3→a22.
  - a13, a23, a31, a32 forced 0; a33 forced +1.
- First element (k=0):
  - size_sel latched into out_size.
  - Whole out_matrix cleared to the size's filler pattern in the same edge as the element write: all 0, or, for 2x2, a33=1.
- LOAD→FULL: on acceptance of the last element (k=8 for 3x3, k=3 for 2x2).
  - out_valid asserts the cycle after that handshake; latency = 1 cycle.
  - elem_cnt holds 9 or 4.
- FULL→LOAD: on out handshake.
  - elem_cnt←0 and out_valid←0 next cycle.
  - out_matrix retains its value until the next first element is accepted.
  - One bubble cycle between matrices.
- While FULL:
  - out_matrix, out_size and out_valid are held stable regardless of out_ready (no valid drop without handshake).
  - in_data is ignored.
- size_sel changes after k=0 are ignored until the next matrix.
- clear=1: next state LOAD, elem_cnt=0, out_valid=0; out_matrix/out_size unchanged.
  - clear has priority over a simultaneous input or output handshake.
  - An element presented with clear is not accepted, but in_ready still reads 1 in LOAD that cycle; the source must treat clear as a discard.
- rst low mid-load or while FULL: all state returns to reset values; partial matrix lost.
- Arithmetic: none; elements are passed bit-exact, sign-preserving.

Optional Feature:
- Macro: MATLOAD_COLMAJOR_EN.
- Defined: elements arrive column-major.
  - 3x3: element k written to matrix position row=k%3, col=k/3, i.e. packed index 3*(k%3)+(k/3).
  - 2x2: k=0→a11, k=1→a21, k=2→a12, k=3→a22.
- Undefined: row-major placement as above.
- All handshake, timing, count and filler behaviour is identical in both builds.

Test Plan:
- Reset then 3x3 load: rst=0 for 5 cycles, release; stream 1,2,2,0,4,1,3,5,1 with in_valid=1, out_ready=0.
  - Required: out_matrix=72'h010202_000401_030501 and out_valid=1 one cycle after the 9th handshake.
  - Required: in_ready=0 and out_matrix stable while out_ready stays 0 for 10 cycles.
  - Downstream det=-19.
- Output handshake: from the FULL state above, pulse out_ready=1 for one cycle.
  - Required: out_valid=0 and in_ready=1 next cycle; elem_cnt=0.
  - Required: the next matrix 9..1 is loaded correctly with no residue from the previous matrix.
- 2x2 load: size_sel=1 with first element; stream 3,1,2,4.
  - Required: out_matrix=72'h030100_020400_000001, out_size=1, out_valid after 4 handshakes.
  - Downstream det=10.
- Backpressure/gaps: in_valid toggled 1,0,0,1,... across a 3x3 load → elem_cnt increments only on handshake cycles; result equals the gap-free load.
- Clear mid-load: clear=1 after 5 elements, with in_valid=1 in the same cycle.
  - Required: elem_cnt=0, out_valid=0, and that element is not counted.
  - A subsequent full 9-element load completes normally.
- Reset while FULL: rst=0 for one edge while out_valid=1 → out_valid=0, out_matrix=0, elem_cnt=0.
  - With MATLOAD_COLMAJOR_EN defined, stream 1,0,3,2,4,5,2,1,1 → out_matrix equals the first scenario's value.

Source files
------------

// File: rtl/matrix_loader.sv
// matrix_loader: streams signed elements into a packed 3x3 (or embedded 2x2) matrix with valid/ready on both sides; define MATLOAD_COLMAJOR_EN for column-major element order
module matrix_loader #(
    parameter int ELEM_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  size_sel,
    input  logic [ELEM_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [9*ELEM_W-1:0]   out_matrix,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_size,
    output logic [3:0]            elem_cnt
);
    localparam int MW = 9 * ELEM_W;
    typedef enum logic {LOAD, FULL} state_t;
    state_t state, state_n;
    logic acc, eff_size, last;
    logic [3:0] idx;
    logic [MW-1:0] mat_n;
    assign in_ready  = rst && state == LOAD;
    assign out_valid = state == FULL;
    assign acc       = in_valid && in_ready && !clear;
    assign eff_size  = elem_cnt == 4'd0 ? size_sel : out_size;
    assign last      = elem_cnt == (eff_size ? 4'd3 : 4'd8);
    // packed slot (0 = a11 .. 8 = a33) that the current element lands in
    always_comb begin
`ifdef MATLOAD_COLMAJOR_EN
        idx = eff_size ? (elem_cnt == 4'd1 ? 4'd3 : elem_cnt == 4'd2 ? 4'd1 : elem_cnt == 4'd3 ? 4'd4 : 4'd0)
                       : 4'(3 * (elem_cnt % 3) + elem_cnt / 3);
`else
        idx = eff_size && elem_cnt >= 4'd2 ? elem_cnt + 4'd1 : elem_cnt;
`endif
    end
    // first element starts from the size's filler pattern, later ones patch the held matrix
    always_comb begin
        mat_n = elem_cnt == 4'd0 ? (eff_size ? MW'(1) : '0) : out_matrix;
        mat_n[ELEM_W*(8-int'(idx)) +: ELEM_W] = in_data;
    end
    // next state: clear wins over both handshakes
    always_comb begin
        state_n = state;
        if (clear)
            state_n = LOAD;
        else if (state == LOAD && acc && last)
            state_n = FULL;
        else if (state == FULL && out_ready)
            state_n = LOAD;
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= LOAD;
        else
            state <= state_n;
    end
    // element count, matrix and latched size; matrix survives clear and output handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            elem_cnt   <= '0;
            out_matrix <= '0;
            out_size   <= 1'b0;
        end else if (clear) begin
            elem_cnt <= '0;
        end else if (acc) begin
            elem_cnt   <= elem_cnt + 4'd1;
            out_matrix <= mat_n;
            if (elem_cnt == 4'd0)
                out_size <= size_sel;
        end else if (state == FULL && out_ready) begin
            elem_cnt <= '0;
        end
    end
endmodule
